// File: rtl/sram_requester_if.sv
// Bundles the two CPU client ports (fetch, data) and the SRAM controller request port.
// master = the requester itself, slave = the clients and controller around it.
interface sram_requester_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 18
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ack;

  logic              busy;

  logic              mem_en;
  logic              mem_op;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_ack, dm_rdata, dm_ack, busy,
           mem_en, mem_op, mem_addr, mem_wdata
  );

  modport slave (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_ack, dm_rdata, dm_ack, busy,
           mem_en, mem_op, mem_addr, mem_wdata
  );
endinterface

// File: rtl/sram_requester.sv
// Arbitrates instruction fetch and data memory clients onto one SRAM controller port,
// running one four-cycle IDLE/ISSUE/HOLD/ACK sequence per access; data port has priority.
module sram_requester #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 18
) (
  input  logic              clk_50MHz,
  input  logic              rst,
  sram_requester_if.master  bus
);

  localparam logic RAM_RD = 1'b0;
  localparam logic RAM_WR = 1'b1;

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD, ACK} state_t;
  typedef enum logic {OWN_IF, OWN_DM} owner_t;

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_op_q, mem_op_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              busy_q, busy_d;

  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      mem_en_q    <= 1'b0;
      mem_op_q    <= RAM_RD;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_en_q    <= mem_en_d;
      mem_op_q    <= mem_op_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_en_d    = mem_en_q;
    mem_op_d    = mem_op_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = if_ack_q;
    dm_ack_d    = dm_ack_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;

    case (state_q)
      IDLE: begin
        // Op, address and write data are only latched here, so they stay
        // stable for the controller until the sequence returns to IDLE.
        if (bus.dm_req) begin
          mem_addr_d  = bus.dm_addr;
          mem_wdata_d = bus.dm_wdata;
          mem_op_d    = bus.dm_we ? RAM_WR : RAM_RD;
          owner_d     = OWN_DM;
          mem_en_d    = 1'b1;
          state_d     = ISSUE;
        end else if (bus.if_req) begin
          mem_addr_d  = bus.if_addr;
          mem_op_d    = RAM_RD;
          owner_d     = OWN_IF;
          mem_en_d    = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        mem_en_d = 1'b0;
        state_d  = HOLD;
      end
      HOLD: begin
        if (mem_op_q == RAM_RD) begin
          if (owner_q == OWN_DM) dm_rdata_d = bus.mem_rdata;
          else                   if_rdata_d = bus.mem_rdata;
        end
        if (owner_q == OWN_DM) dm_ack_d = 1'b1;
        else                   if_ack_d = 1'b1;
        state_d = ACK;
      end
      ACK: begin
        if_ack_d = 1'b0;
        dm_ack_d = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_op    = mem_op_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.dm_ack    = dm_ack_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_sram_requester.sv
// Scoreboard bench for sram_requester: per-client expectation queues filled at issue time,
// drained by a bus monitor that also checks transaction timing and held read data.
module tb_sram_requester;

  localparam logic RAM_RD = 1'b0;
  localparam logic RAM_WR = 1'b1;
  localparam int   DEPTH  = 1 << 18;

  typedef struct packed {
    logic [17:0] addr;
    logic        we;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } exp_t;

  logic clk_50MHz = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cycle = 0;

  exp_t exp_if[$];
  exp_t exp_dm[$];

  logic [15:0] sram    [0:DEPTH-1];
  logic [15:0] ref_mem [0:DEPTH-1];

  sram_requester_if bus ();

  sram_requester dut (
    .clk_50MHz (clk_50MHz),
    .rst       (rst),
    .bus       (bus)
  );

  always #10 clk_50MHz = ~clk_50MHz;
  always @(posedge clk_50MHz) cycle++;

  // Controller stand-in: read data is presented from the latched address,
  // writes land when the enable pulse is sampled.
  assign bus.mem_rdata = sram[bus.mem_addr];
  always @(posedge clk_50MHz)
    if (rst && bus.mem_en && bus.mem_op == RAM_WR)
      sram[bus.mem_addr] <= bus.mem_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cycle);
    end
  endtask

  // Monitor
  int          ph = -1;
  logic [17:0] cap_addr;
  logic        cap_op;
  logic [15:0] cap_wdata;
  logic [15:0] model_if_rdata = '0;
  logic [15:0] model_dm_rdata = '0;

  always @(negedge clk_50MHz) begin
    exp_t e;
    if (!rst) begin
      chk("rst_mem_en", bus.mem_en, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_acks", {bus.if_ack, bus.dm_ack}, 0);
      chk("rst_mem_op", bus.mem_op, RAM_RD);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_rdata", {bus.if_rdata, bus.dm_rdata}, 0);
      ph = -1;
      model_if_rdata = '0;
      model_dm_rdata = '0;
    end else begin
      if (bus.mem_en) begin
        chk("en_overlap", ph, -1);
        chk("en_expected", (exp_if.size() + exp_dm.size()) != 0, 1);
        ph        = 0;
        cap_addr  = bus.mem_addr;
        cap_op    = bus.mem_op;
        cap_wdata = bus.mem_wdata;
      end else if (ph >= 0) begin
        ph++;
        chk("bus_stable", {bus.mem_op, bus.mem_addr, bus.mem_wdata}, {cap_op, cap_addr, cap_wdata});
      end
      chk("busy", bus.busy, (ph >= 0 && ph <= 2));
      if (ph == 2 || bus.if_ack || bus.dm_ack) begin
        chk("ack_timing", {ph == 2, bus.if_ack | bus.dm_ack, bus.if_ack & bus.dm_ack}, 3'b110);
        if (bus.if_ack) begin
          chk("if_queue_nonempty", exp_if.size() != 0, 1);
          if (exp_if.size() != 0) begin
            e = exp_if.pop_front();
            chk("if_addr", cap_addr, e.addr);
            chk("if_op", cap_op, RAM_RD);
            model_if_rdata = e.rdata;
          end
        end
        if (bus.dm_ack) begin
          chk("dm_queue_nonempty", exp_dm.size() != 0, 1);
          if (exp_dm.size() != 0) begin
            e = exp_dm.pop_front();
            chk("dm_addr", cap_addr, e.addr);
            chk("dm_op", cap_op, e.we ? RAM_WR : RAM_RD);
            if (e.we) chk("dm_wdata", cap_wdata, e.wdata);
            else      model_dm_rdata = e.rdata;
          end
        end
        ph = -1;
      end
      chk("if_rdata", bus.if_rdata, model_if_rdata);
      chk("dm_rdata", bus.dm_rdata, model_dm_rdata);
    end
  end

  // Stimulus helpers
  task automatic preload(input logic [17:0] a, input logic [15:0] d);
    sram[a]    = d;
    ref_mem[a] = d;
  endtask

  task automatic issue_if(input logic [17:0] a);
    exp_t e;
    e.addr = a; e.we = 1'b0; e.wdata = '0; e.rdata = ref_mem[a];
    exp_if.push_back(e);
    bus.if_addr = a;
    bus.if_req  = 1'b1;
  endtask

  task automatic issue_dm(input logic we, input logic [17:0] a, input logic [15:0] wd);
    exp_t e;
    e.addr = a; e.we = we; e.wdata = wd; e.rdata = we ? 16'h0 : ref_mem[a];
    if (we) ref_mem[a] = wd;
    exp_dm.push_back(e);
    bus.dm_we    = we;
    bus.dm_addr  = a;
    bus.dm_wdata = wd;
    bus.dm_req   = 1'b1;
  endtask

  task automatic wait_ack(input bit dm, input bit keep, output int cyc);
    bit got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk_50MHz);
      if (dm ? bus.dm_ack : bus.if_ack) got = 1;
    end
    cyc = cycle;
    chk(dm ? "dm_ack_timeout" : "if_ack_timeout", got, 1);
    if (!keep) begin
      if (dm) bus.dm_req = 1'b0;
      else    bus.if_req = 1'b0;
    end
  endtask

  task automatic wait_en();
    bit got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk_50MHz);
      if (bus.mem_en) got = 1;
    end
    chk("mem_en_timeout", got, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cycle);
    $fatal(1, "watchdog");
  end

  initial begin
    int c_if, c_dm, prev;
    bus.if_req = 0; bus.if_addr = '0;
    bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = '0; bus.dm_wdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sram[i]    = 16'($urandom);
      ref_mem[i] = sram[i];
    end
    preload(18'h00100, 16'hA5C3);
    preload(18'h00010, 16'hBEEF);
    preload(18'h00020, 16'h0F0F);

    // Reset, then idle
    repeat (3) @(posedge clk_50MHz);
    @(negedge clk_50MHz) rst = 1'b1;
    repeat (10) @(negedge clk_50MHz);
    $display("idle after reset: busy=%0b mem_en=%0b", bus.busy, bus.mem_en);

    // Single fetch
    @(posedge clk_50MHz); #1;
    issue_if(18'h00100);
    wait_ack(0, 0, c_if);
    chk("fetch_rdata", bus.if_rdata, 16'hA5C3);
    $display("fetch 00100 -> %h at cycle %0d", bus.if_rdata, c_if);

    // Data write at the top address, then read it back
    @(posedge clk_50MHz); #1;
    issue_dm(1'b1, 18'h3FFFF, 16'h1234);
    wait_ack(1, 0, c_dm);
    $display("write 3ffff <- 1234 at cycle %0d", c_dm);
    @(posedge clk_50MHz); #1;
    issue_dm(1'b0, 18'h3FFFF, 16'h0);
    wait_ack(1, 0, c_dm);
    chk("write_readback", bus.dm_rdata, 16'h1234);
    $display("read 3ffff -> %h", bus.dm_rdata);

    // Contention: data wins, fetch follows one access later
    @(posedge clk_50MHz); #1;
    issue_dm(1'b0, 18'h00010, 16'h0);
    issue_if(18'h00020);
    fork
      wait_ack(1, 0, c_dm);
      wait_ack(0, 0, c_if);
    join
    chk("contention_order", c_if - c_dm, 4);
    chk("contention_dm", bus.dm_rdata, 16'hBEEF);
    chk("contention_if", bus.if_rdata, 16'h0F0F);
    $display("contention: dm ack cycle %0d, if ack cycle %0d", c_dm, c_if);

    // Back-to-back fetches with request held high
    @(posedge clk_50MHz); #1;
    issue_if(18'h0);
    prev = 0;
    for (int i = 0; i < 8; i++) begin
      wait_ack(0, i < 7, c_if);
      if (i > 0) chk("b2b_spacing", c_if - prev, 4);
      $display("b2b fetch %0d -> %h at cycle %0d", i, bus.if_rdata, c_if);
      prev = c_if;
      if (i < 7) issue_if(18'(i + 1));
    end

    // Request dropped before its ack still completes
    @(posedge clk_50MHz); #1;
    issue_dm(1'b0, 18'h20003, 16'h0);
    wait_en();
    bus.dm_req = 1'b0;
    wait_ack(1, 0, c_dm);
    $display("early-drop read 20003 -> %h", bus.dm_rdata);

    // Randomized concurrent traffic
    fork
      begin
        int c;
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk_50MHz);
          #1;
          issue_if(18'($urandom_range(0, 18'h1FFFF)));
          wait_ack(0, 0, c);
          $display("rand fetch %h -> %h", bus.if_addr, bus.if_rdata);
        end
      end
      begin
        int c;
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk_50MHz);
          #1;
          issue_dm(1'($urandom_range(0, 1)), 18'h20000 + 18'($urandom_range(0, 15)), 16'($urandom));
          wait_ack(1, 0, c);
          $display("rand dm we=%0b %h wd=%h rd=%h", bus.dm_we, bus.dm_addr, bus.dm_wdata, bus.dm_rdata);
        end
      end
    join

    // Reset while a data read sits in HOLD
    @(posedge clk_50MHz); #1;
    issue_dm(1'b0, 18'h20005, 16'h0);
    wait_en();
    @(negedge clk_50MHz);
    chk("pre_reset_busy", bus.busy, 1);
    #3 rst = 1'b0;
    #1;
    chk("mid_rst_mem_en", bus.mem_en, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_acks", {bus.if_ack, bus.dm_ack}, 0);
    exp_dm.delete();
    bus.dm_req = 1'b0;
    repeat (3) @(posedge clk_50MHz);
    #1 chk("mid_rst_no_ack", bus.dm_ack, 0);
    @(negedge clk_50MHz) rst = 1'b1;
    $display("reset during HOLD: busy=%0b dm_ack=%0b", bus.busy, bus.dm_ack);
    repeat (2) @(posedge clk_50MHz);
    #1;
    issue_if(18'h00100);
    wait_ack(0, 0, c_if);
    chk("post_rst_fetch", bus.if_rdata, 16'hA5C3);
    $display("fetch after reset -> %h", bus.if_rdata);

    repeat (4) @(posedge clk_50MHz);
    chk("queues_drained", exp_if.size() + exp_dm.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
